// File: rtl/mc_control_pkg.sv
// Shared encodings for the multicycle MIPS main control FSM.
// Holds the state codes, the opcodes the controller understands, the ALUOp
// codes and a helper that says whether an opcode is decodable.
// Optional feature macro: MC_CONTROL_IMMEDIATE_EN (enables addi decoding).
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADDR   = 4'd2,
    S_MEMREAD   = 4'd3,
    S_MEMWB     = 4'd4,
    S_MEMWRITE  = 4'd5,
    S_REXEC     = 4'd6,
    S_RWB       = 4'd7,
    S_BEQ       = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // True when DECODE has a successor state for this opcode.
  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: op_supported = 1'b1;
`ifdef MC_CONTROL_IMMEDIATE_EN
      OP_ADDI:                               op_supported = 1'b1;
`endif
      default:                               op_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_if.sv
// Control bundle between the main control FSM and the MIPS datapath.
// master: the controller (takes op/mem_ready, drives enables and selects).
// slave : the datapath/memory side (drives op/mem_ready, takes controls).
interface mc_control_if;
  logic [5:0] op;
  logic       mem_ready;
  logic       pcwrite;
  logic       pcwritecond;
  logic       iord;
  logic       memread;
  logic       memwrite;
  logic       irwrite;
  logic       memtoreg;
  logic       regdst;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsource;
  logic       aluop1;
  logic       aluop0;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  op, mem_ready,
    output pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
           memtoreg, regdst, regwrite, alusrca, alusrcb, pcsource,
           aluop1, aluop0, illegal_op, state
  );

  modport slave (
    output op, mem_ready,
    input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
           memtoreg, regdst, regwrite, alusrca, alusrcb, pcsource,
           aluop1, aluop0, illegal_op, state
  );
endinterface

// File: rtl/mc_control_dec.sv
// Output decoder for the multicycle control FSM: maps the registered state
// (plus mem_ready in FETCH and op in DECODE) to datapath controls.
// Inputs : reset, state, op, mem_ready.
// Outputs: every datapath control plus the debug state view.
// Reset gates everything to zero combinationally so an interrupted
// instruction loses its write enables in the same cycle reset rises.
// Optional feature macro: MC_CONTROL_IMMEDIATE_EN (ADDI_EXEC/ADDI_WB outputs).
module mc_control_dec
  import mips_ctrl_pkg::*;
(
  input  logic       reset,
  input  state_t     state,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsource,
  output logic       aluop1,
  output logic       aluop0,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  logic [1:0] aluop;

  assign aluop1    = aluop[1];
  assign aluop0    = aluop[0];
  assign state_dbg = reset ? 4'd0 : state;

  always_comb begin
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    pcsource    = 2'b00;
    aluop       = ALUOP_ADD;
    illegal_op  = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          memread = 1'b1;
          alusrcb = 2'b01;
          // IR and PC only update on the cycle the fetch completes.
          irwrite = mem_ready;
          pcwrite = mem_ready;
        end
        S_DECODE: begin
          alusrcb    = 2'b11;
          illegal_op = !op_supported(op);
        end
        S_MEMADDR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        S_MEMREAD: begin
          memread = 1'b1;
          iord    = 1'b1;
        end
        S_MEMWRITE: begin
          memwrite = 1'b1;
          iord     = 1'b1;
        end
        S_MEMWB: begin
          regwrite = 1'b1;
          memtoreg = 1'b1;
        end
        S_REXEC: begin
          alusrca = 1'b1;
          aluop   = ALUOP_FUNCT;
        end
        S_RWB: begin
          regwrite = 1'b1;
          regdst   = 1'b1;
        end
        S_BEQ: begin
          alusrca     = 1'b1;
          aluop       = ALUOP_SUB;
          pcwritecond = 1'b1;
          pcsource    = 2'b01;
        end
        S_JUMP: begin
          pcwrite  = 1'b1;
          pcsource = 2'b10;
        end
`ifdef MC_CONTROL_IMMEDIATE_EN
        S_ADDI_EXEC: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        S_ADDI_WB: begin
          regwrite = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle main control FSM for the MIPS datapath.
// Ports: clk, reset (synchronous, active-high), bus (mc_control_if.master)
// carrying op/mem_ready in and all datapath controls plus debug state out.
// This level holds only the state register and next-state logic; output
// decoding lives in mc_control_dec.
// Optional feature macro: MC_CONTROL_IMMEDIATE_EN (addi via ADDI_EXEC/ADDI_WB).
module mc_control
  import mips_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  mc_control_if.master bus
);

  state_t state_reg;
  state_t state_next;

  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH:    state_next = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_next = S_MEMADDR;
          OP_RTYPE:     state_next = S_REXEC;
          OP_BEQ:       state_next = S_BEQ;
          OP_J:         state_next = S_JUMP;
`ifdef MC_CONTROL_IMMEDIATE_EN
          OP_ADDI:      state_next = S_ADDI_EXEC;
`endif
          default:      state_next = S_FETCH;
        endcase
      end
      // op is re-examined here; anything other than lw/sw abandons the access.
      S_MEMADDR: begin
        if (bus.op == OP_LW)      state_next = S_MEMREAD;
        else if (bus.op == OP_SW) state_next = S_MEMWRITE;
        else                      state_next = S_FETCH;
      end
      S_MEMREAD:  state_next = bus.mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_next = bus.mem_ready ? S_FETCH : S_MEMWRITE;
      S_REXEC:    state_next = S_RWB;
`ifdef MC_CONTROL_IMMEDIATE_EN
      S_ADDI_EXEC: state_next = S_ADDI_WB;
`endif
      // MEMWB, RWB, BEQ, JUMP, ADDI_WB and any stray code all restart fetch.
      default:    state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_FETCH;
    else       state_reg <= state_next;
  end

  mc_control_dec u_dec (
    .reset       (reset),
    .state       (state_reg),
    .op          (bus.op),
    .mem_ready   (bus.mem_ready),
    .pcwrite     (bus.pcwrite),
    .pcwritecond (bus.pcwritecond),
    .iord        (bus.iord),
    .memread     (bus.memread),
    .memwrite    (bus.memwrite),
    .irwrite     (bus.irwrite),
    .memtoreg    (bus.memtoreg),
    .regdst      (bus.regdst),
    .regwrite    (bus.regwrite),
    .alusrca     (bus.alusrca),
    .alusrcb     (bus.alusrcb),
    .pcsource    (bus.pcsource),
    .aluop1      (bus.aluop1),
    .aluop0      (bus.aluop0),
    .illegal_op  (bus.illegal_op),
    .state_dbg   (bus.state)
  );

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control. Each instruction is expanded into its expected
// per-cycle state trace from the transition rules, with mem_ready stalls
// inserted, and outputs are predicted from the per-state output table.
module tb_mc_control;

  localparam int FETCH = 0, DECODE = 1, MEMADDR = 2, MEMREAD = 3, MEMWB = 4,
                 MEMWRITE = 5, REXEC = 6, RWB = 7, BEQ = 8, JUMP = 9,
                 ADDI_EXEC = 10, ADDI_WB = 11;

  localparam logic [5:0] RTYPE = 6'b000000, LW = 6'b100011, SW = 6'b101011,
                         BEQOP = 6'b000100, JOP = 6'b000010, ADDI = 6'b001000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  mc_control_if bus ();

  mc_control dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

`ifdef MC_CONTROL_IMMEDIATE_EN
  localparam bit IMM_EN = 1'b1;
`else
  localparam bit IMM_EN = 1'b0;
`endif

  function automatic bit legal(input logic [5:0] op);
    return op == RTYPE || op == LW || op == SW || op == BEQOP || op == JOP ||
           (IMM_EN && op == ADDI);
  endfunction

  // {pcwrite,pcwritecond,iord,memread,memwrite,irwrite,memtoreg,regdst,
  //  regwrite,alusrca,alusrcb[1:0],pcsource[1:0],aluop[1:0],illegal_op}
  function automatic logic [16:0] exp_out(input int st, input bit mr, input logic [5:0] op);
    logic pw = 0, pwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, rd = 0, rw = 0, sa = 0, ill = 0;
    logic [1:0] sb = 0, ps = 0, ao = 0;
    case (st)
      FETCH:     begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
      DECODE:    begin sb = 2'b11; ill = !legal(op); end
      MEMADDR:   begin sa = 1; sb = 2'b10; end
      MEMREAD:   begin mrd = 1; iord = 1; end
      MEMWRITE:  begin mwr = 1; iord = 1; end
      MEMWB:     begin rw = 1; m2r = 1; end
      REXEC:     begin sa = 1; ao = 2'b10; end
      RWB:       begin rw = 1; rd = 1; end
      BEQ:       begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
      JUMP:      begin pw = 1; ps = 2'b10; end
      ADDI_EXEC: begin sa = 1; sb = 2'b10; end
      ADDI_WB:   begin rw = 1; end
      default: ;
    endcase
    return {pw, pwc, iord, mrd, mwr, irw, m2r, rd, rw, sa, sb, ps, ao, ill};
  endfunction

  function automatic logic [16:0] obs_out();
    return {bus.pcwrite, bus.pcwritecond, bus.iord, bus.memread, bus.memwrite,
            bus.irwrite, bus.memtoreg, bus.regdst, bus.regwrite, bus.alusrca,
            bus.alusrcb, bus.pcsource, bus.aluop1, bus.aluop0, bus.illegal_op};
  endfunction

  // Runs one instruction from its first FETCH cycle; wf/wm are stall cycles
  // in FETCH and in the memory-access state.
  task automatic run_instr(input string name, input logic [5:0] op, input int wf, input int wm);
    int st_q[$];
    bit mr_q[$];
    for (int i = 0; i < wf; i++) begin st_q.push_back(FETCH); mr_q.push_back(1'b0); end
    st_q.push_back(FETCH);  mr_q.push_back(1'b1);
    st_q.push_back(DECODE); mr_q.push_back(1'($urandom));
    if (op == LW || op == SW) begin
      st_q.push_back(MEMADDR); mr_q.push_back(1'($urandom));
      for (int i = 0; i < wm; i++) begin
        st_q.push_back(op == LW ? MEMREAD : MEMWRITE); mr_q.push_back(1'b0);
      end
      st_q.push_back(op == LW ? MEMREAD : MEMWRITE); mr_q.push_back(1'b1);
      if (op == LW) begin st_q.push_back(MEMWB); mr_q.push_back(1'($urandom)); end
    end else if (op == RTYPE) begin
      st_q.push_back(REXEC); mr_q.push_back(1'($urandom));
      st_q.push_back(RWB);   mr_q.push_back(1'($urandom));
    end else if (op == BEQOP) begin
      st_q.push_back(BEQ);   mr_q.push_back(1'($urandom));
    end else if (op == JOP) begin
      st_q.push_back(JUMP);  mr_q.push_back(1'($urandom));
    end else if (op == ADDI && IMM_EN) begin
      st_q.push_back(ADDI_EXEC); mr_q.push_back(1'($urandom));
      st_q.push_back(ADDI_WB);   mr_q.push_back(1'($urandom));
    end
    for (int i = 0; i < st_q.size(); i++) begin
      logic [5:0] drv_op;
      // op only matters in DECODE/MEMADDR; scramble it elsewhere.
      drv_op = (st_q[i] == DECODE || st_q[i] == MEMADDR) ? op : 6'($urandom);
      @(negedge clk);
      bus.op = drv_op;
      bus.mem_ready = mr_q[i];
      #1;
      checks++;
      if (bus.state !== 4'(st_q[i])) begin
        failures++;
        $display("FAIL %s state cyc=%0d got=%0d want=%0d", name, i, bus.state, st_q[i]);
      end
      checks++;
      if (obs_out() !== exp_out(st_q[i], mr_q[i], drv_op)) begin
        failures++;
        $display("FAIL %s outputs cyc=%0d state=%0d got=%h want=%h", name, i, st_q[i],
                 obs_out(), exp_out(st_q[i], mr_q[i], drv_op));
      end
    end
    $display("instr %s op=%b wf=%0d wm=%0d cycles=%0d", name, op, wf, wm, st_q.size());
  endtask

  task automatic test_reset();
    bus.op = 6'b111111;
    bus.mem_ready = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (obs_out() !== 17'd0 || bus.state !== 4'd0) begin
        failures++;
        $display("FAIL reset_hold got=%h state=%0d want=0", obs_out(), bus.state);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    checks++;
    if (bus.state !== 4'd0 || obs_out() !== exp_out(FETCH, 1'b1, bus.op)) begin
      failures++;
      $display("FAIL reset_release got=%h state=%0d want=%h state=0",
               obs_out(), bus.state, exp_out(FETCH, 1'b1, bus.op));
    end
    // Unsupported opcode follows: one DECODE cycle with illegal_op, then FETCH.
    @(negedge clk);
    #1;
    checks++;
    if (bus.state !== 4'd1 || bus.illegal_op !== 1'b1) begin
      failures++;
      $display("FAIL reset_illegal state=%0d ill=%b want state=1 ill=1", bus.state, bus.illegal_op);
    end
    $display("instr reset_release op=%b", bus.op);
  endtask

  task automatic test_directed();
    run_instr("lw",      LW,    0, 0);
    run_instr("rtype",   RTYPE, 0, 0);
    run_instr("sw_wait", SW,    0, 3);
    run_instr("beq",     BEQOP, 0, 0);
    run_instr("j",       JOP,   1, 0);
    run_instr("illegal", 6'b111111, 0, 0);
    run_instr("addi",    ADDI,  0, 0);
    run_instr("lw_wait", LW,    2, 2);
  endtask

  task automatic test_reset_mid();
    int seq[3] = '{FETCH, DECODE, MEMADDR};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.op = LW;
      bus.mem_ready = 1'b1;
      #1;
      checks++;
      if (bus.state !== 4'(seq[i])) begin
        failures++;
        $display("FAIL reset_mid_lead state got=%0d want=%0d", bus.state, seq[i]);
      end
    end
    @(negedge clk);          // would be MEMREAD
    reset = 1'b1;
    bus.mem_ready = 1'b0;
    #1;
    checks++;
    if (obs_out() !== 17'd0 || bus.state !== 4'd0) begin
      failures++;
      $display("FAIL reset_mid_abort got=%h state=%0d want=0", obs_out(), bus.state);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (bus.state !== 4'd0 || obs_out() !== exp_out(FETCH, 1'b0, bus.op)) begin
      failures++;
      $display("FAIL reset_mid_fetch got=%h state=%0d want=%h state=0",
               obs_out(), bus.state, exp_out(FETCH, 1'b0, bus.op));
    end
    $display("instr reset_mid op=%b", LW);
  endtask

  task automatic test_random();
    logic [5:0] ops[7] = '{RTYPE, LW, SW, BEQOP, JOP, ADDI, 6'b111111};
    for (int n = 0; n < 40; n++) begin
      logic [5:0] op;
      op = ops[$urandom_range(0, 6)];
      if ($urandom_range(0, 6) == 0) op = 6'($urandom);
      run_instr("random", op, $urandom_range(0, 2), $urandom_range(0, 3));
    end
  endtask

  initial begin
    bus.op = 6'd0;
    bus.mem_ready = 1'b0;
    test_reset();
    test_directed();
    test_reset_mid();
    test_random();
    // Last instruction must hand back to FETCH.
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    checks++;
    if (bus.state !== 4'd0) begin
      failures++;
      $display("FAIL final_fetch state got=%0d want=0", bus.state);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
